bitwise_stream_reduce: RTL and testbench
========================================

# bitwise_stream_reduce

Parametrised, sequential successor to the combinational two-operand OR block.
- Accepts a length-prefixed stream of WIDTH-bit operands over a valid/ready handshake.
- Folds them together one beat per cycle with a selectable bitwise operation (OR, AND, XOR, NOR).
- Returns a single registered result over an output valid/ready handshake.
- Sits between the register-file read path and the ALU result mux as the multi-operand logic unit.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (>=1)
- MAX_LEN, 16, maximum operands per reduction (>=1); CW = $clog2(MAX_LEN+1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a reduction; sampled only in IDLE
- op  in  2  operation, sampled with start: 00 OR, 01 AND, 10 XOR, 11 NOR
- len  in  CW  operand count, sampled with start
- in_valid  in  1  operand beat valid
- in_data  in  WIDTH  operand
- in_ready  out  1  block accepts an operand this cycle
- out_valid  out  1  result valid
- out_data  out  WIDTH  result
- out_ready  in  1  downstream accepts the result
- busy  out  1  state != IDLE
- len_err  out  1  one-cycle pulse when start is given with an illegal len

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE:**
  - in_ready=0, out_valid=0.
  - On start with 1<=len<=MAX_LEN:
    - latch op and len;
    - clear the beat counter;
    - load the accumulator with the identity: all-zeros for OR/XOR/NOR, all-ones for AND;
    - go to ACC.
  - On start with len==0 or len>MAX_LEN: pulse len_err for one cycle and stay in IDLE.
- **ACC:**
  - in_ready=1.
  - Each in_valid&&in_ready beat: acc <= acc OPB in_data, where OPB is OR for OR/NOR, AND for AND, XOR for XOR; the counter increments.
  - The beat on which the counter reaches the latched len is the last beat:
    - out_data <= final value, inverted when op==NOR;
    - go to DONE.
  - in_valid low stalls with no state change.
- **DONE:**
  - out_valid=1, in_ready=0.
  - out_data is held stable until out_valid&&out_ready, then go to IDLE.
- start is ignored outside IDLE. op and len changes after start have no effect.
- len==1 case: out_data equals the single operand (bitwise inverted for NOR).
- Reset (any cycle, mid-stream included):
  - state=IDLE;
  - in_ready=0, out_valid=0, len_err=0;
  - out_data=0, accumulator=0, counter=0.
  - The partial reduction is discarded and no result is produced.

## Timing
- start sampled at edge 0 -> in_ready high from cycle 1.
- Throughput: one operand per cycle while in_valid is held high.
- Latency: last beat accepted at edge k -> out_valid high in cycle k+1 (registered, no combinational in->out path).
- With out_ready already high, DONE lasts exactly one cycle. IDLE is then entered, and a new start is accepted the following cycle.
- Minimum reduction period: len+2 cycles (start, len beats, result).
- len_err is asserted in the cycle after the illegal start and is never asserted in the same cycle as busy.
- All outputs are registered except in_ready and busy, which are decoded from state only. None depends combinationally on inputs.

## Structure
- Shared package bitwise_pkg holds:
  - op encoding constants OP_OR/OP_AND/OP_XOR/OP_NOR;
  - FSM state encoding;
  - an identity-value function parametrised by WIDTH.
- Sub-module bitwise_op2 (parametrised WIDTH, purely combinational two-operand OR/AND/XOR select) is instantiated once for the accumulator update. It is a generalisation of the existing two-operand block.
- The FSM, counter and accumulator stay in the top module.

## Test plan
- OR, len=3, operands 0x0000_000F, 0x0000_00F0, 0x0000_0F00, out_ready=1 -> out_data=0x0000_0FFF, out_valid high exactly one cycle, busy low the next cycle.
- AND, len=2, operands 0xFFFF_0000, 0xF0F0_F0F0 -> 0xF0F0_0000. NOR, len=1, operand 0x0000_0001 -> 0xFFFF_FFFE.
- XOR, len=MAX_LEN=16, every operand 0xA5A5_A5A5, in_valid toggled randomly -> out_data=0x0000_0000, accepted beat count exactly 16.
- Start with len=0 and with len=17 -> len_err one-cycle pulse each, busy stays 0, no in_ready. A second start asserted while busy -> ignored.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, extra in_valid beats not consumed.
- Assert rst_n low after 2 of 4 beats -> all outputs at reset values immediately. A fresh OR reduction of len=2 then gives the correct result with no contamination from the aborted run.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared definitions for the multi-operand bitwise reduction unit.
//   op_e         : operation encoding carried on the 2-bit op port
//   state_e      : reduction FSM state encoding
//   identity_bit : fill bit of the accumulator start value for an operation
package bitwise_pkg;

  // Operation select; NOR folds as OR and inverts once at the end.
  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Identity of the fold operator, as the bit replicated across WIDTH:
  // all-ones for AND, all-zeros for OR/XOR/NOR.
  function automatic logic identity_bit(input op_e op);
    return (op == OP_AND);
  endfunction

endpackage

// File: rtl/bitwise_op2.sv
// Two-operand bitwise logic unit (combinational).
//   a, b : WIDTH-bit operands
//   op   : operation; OP_NOR is treated as OR (the caller applies the inversion)
//   y_c  : combinational result
module bitwise_op2
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y_c
);

  // Operator select
  always_comb begin
    y_c = a | b;
    case (op)
      OP_AND:  y_c = a & b;
      OP_XOR:  y_c = a ^ b;
      default: y_c = a | b;
    endcase
  end

endmodule

// File: rtl/bitwise_stream_reduce.sv
// Multi-operand bitwise reduction over a length-prefixed valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op, len      : command, sampled only in IDLE
//   in_valid/in_ready   : operand handshake (in_ready decoded from state)
//   in_data             : operand
//   out_valid/out_ready : result handshake
//   out_data            : registered result, held until accepted
//   busy                : state != IDLE (decoded from state)
//   len_err             : one-cycle pulse after a start with illegal len
module bitwise_stream_reduce
  import bitwise_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned MAX_LEN = 16,
  localparam int unsigned CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CW-1:0]    len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             len_err
);

  state_e           state, state_nxt;
  op_e              op_q, op_nxt;
  logic [CW-1:0]    len_q, len_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] fold_c;
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_valid_nxt;
  logic             len_err_nxt;
  logic             len_ok_c;

  assign len_ok_c = (len != '0) && (len <= CW'(MAX_LEN));
  assign cnt_inc  = cnt + CW'(1);

  // Accumulator update: acc OP in_data
  bitwise_op2 #(.WIDTH(WIDTH)) u_op2 (
    .a   (acc),
    .b   (in_data),
    .op  (op_q),
    .y_c (fold_c)
  );

  // State-decoded handshake/status
  assign in_ready = (state == ST_ACC);
  assign busy     = (state != ST_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_OR;
      len_q     <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      len_q     <= len_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      len_err   <= len_err_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt    = state;
    op_nxt       = op_q;
    len_nxt      = len_q;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    out_data_nxt = out_data;
    len_err_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            op_nxt    = op_e'(op);
            len_nxt   = len;
            cnt_nxt   = '0;
            acc_nxt   = {WIDTH{identity_bit(op_e'(op))}};
            state_nxt = ST_ACC;
          end else begin
            len_err_nxt = 1'b1;
          end
        end
      end

      ST_ACC: begin
        if (in_valid) begin
          acc_nxt = fold_c;
          cnt_nxt = cnt_inc;
          // Last beat: publish the folded value, inverting once for NOR
          if (cnt_inc == len_q) begin
            out_data_nxt = (op_q == OP_NOR) ? ~fold_c : fold_c;
            state_nxt    = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // out_valid tracks DONE one register stage ahead of the state decode
    out_valid_nxt = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_bitwise_stream_reduce.sv
// Self-checking bench for bitwise_stream_reduce: vector table plus
// hand-written sequences for illegal length, ignored start, backpressure
// and mid-stream reset. Results are scoreboarded through a queue.
module tb_bitwise_stream_reduce;
  import bitwise_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CW      = 5;
  localparam int unsigned NVEC    = 7;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic [1:0]       op        = 2'b00;
  logic [CW-1:0]    len       = '0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             len_err;

  always #5 clk = ~clk;

  bitwise_stream_reduce #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .len_err   (len_err)
  );

  typedef struct {
    logic [1:0]       op;
    int unsigned      len;
    logic [WIDTH-1:0] data [MAX_LEN];
    logic             rand_valid;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t             vecs [NVEC];
  logic [WIDTH-1:0] exp_q [$];
  int               checks   = 0;
  int               errors   = 0;
  int               beat_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: counts accepted beats and scoreboards every result transfer
  always @(negedge clk) begin
    if (in_valid && in_ready) beat_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%08h with no result pending at %0t", out_data, $time);
      end else begin
        chk("result", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a reduction, feed all operands, check the result appears one cycle later
  task automatic drive_reduce(input vec_t v);
    int unsigned i;
    int unsigned guard;
    logic        take;
    i     = 0;
    guard = 0;
    exp_q.push_back(v.exp);
    beat_cnt = 0;
    start = 1'b1;
    op    = v.op;
    len   = CW'(v.len);
    step();
    start = 1'b0;
    op    = ~v.op;
    len   = '0;
    chk1("in_ready_after_start", in_ready, 1'b1);
    while (i < v.len && guard < 200) begin
      in_valid = v.rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = v.data[i];
      take     = in_valid && in_ready;
      step();
      if (take) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk("beats_driven", i, v.len);
    chk1("out_valid_latency", out_valid, 1'b1);
    chk1("in_ready_in_done", in_ready, 1'b0);
  endtask

  // With out_ready high the result is gone after exactly one DONE cycle
  task automatic finish_fast(input int unsigned exp_beats);
    step();
    chk1("out_valid_one_cycle", out_valid, 1'b0);
    chk1("busy_after_done", busy, 1'b0);
    chk("beat_count", 32'(beat_cnt), exp_beats);
  endtask

  vec_t v_tmp;
  int   bad_len [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NVEC; k++) begin
      vecs[k].rand_valid = 1'b0;
      for (int j = 0; j < MAX_LEN; j++) vecs[k].data[j] = '0;
    end
    vecs[0].op = OP_OR;  vecs[0].len = 3;  vecs[0].exp = 32'h0000_0FFF;
    vecs[0].data[0] = 32'h0000_000F; vecs[0].data[1] = 32'h0000_00F0; vecs[0].data[2] = 32'h0000_0F00;
    vecs[1].op = OP_AND; vecs[1].len = 2;  vecs[1].exp = 32'hF0F0_0000;
    vecs[1].data[0] = 32'hFFFF_0000; vecs[1].data[1] = 32'hF0F0_F0F0;
    vecs[2].op = OP_NOR; vecs[2].len = 1;  vecs[2].exp = 32'hFFFF_FFFE;
    vecs[2].data[0] = 32'h0000_0001;
    vecs[3].op = OP_XOR; vecs[3].len = 16; vecs[3].exp = 32'h0000_0000; vecs[3].rand_valid = 1'b1;
    for (int j = 0; j < MAX_LEN; j++) vecs[3].data[j] = 32'hA5A5_A5A5;
    vecs[4].op = OP_XOR; vecs[4].len = 3;  vecs[4].exp = 32'h0000_0005;
    vecs[4].data[0] = 32'h0000_0001; vecs[4].data[1] = 32'h0000_0003; vecs[4].data[2] = 32'h0000_0007;
    vecs[5].op = OP_AND; vecs[5].len = 1;  vecs[5].exp = 32'h1234_5678;
    vecs[5].data[0] = 32'h1234_5678;
    vecs[6].op = OP_NOR; vecs[6].len = 2;  vecs[6].exp = 32'hFFFF_FF00;
    vecs[6].data[0] = 32'h0000_00F0; vecs[6].data[1] = 32'h0000_000F;

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_len_err", len_err, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    step();

    // Table-driven reductions, back to back
    for (int k = 0; k < NVEC; k++) begin
      drive_reduce(vecs[k]);
      finish_fast(vecs[k].len);
    end

    // Illegal lengths
    bad_len[0] = 0;
    bad_len[1] = 17;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      op    = OP_OR;
      len   = CW'(bad_len[k]);
      step();
      start = 1'b0;
      chk1("len_err_pulse", len_err, 1'b1);
      chk1("len_err_busy", busy, 1'b0);
      chk1("len_err_in_ready", in_ready, 1'b0);
      step();
      chk1("len_err_clear", len_err, 1'b0);
      chk1("len_err_idle", busy, 1'b0);
    end

    // Second start while busy is ignored
    beat_cnt = 0;
    exp_q.push_back(32'h0000_0101);
    start = 1'b1; op = OP_OR; len = CW'(2);
    step();
    start = 1'b1; op = OP_AND; len = CW'(1);
    in_valid = 1'b1; in_data = 32'h0000_0100;
    step();
    start = 1'b0; in_data = 32'h0000_0001;
    step();
    in_valid = 1'b0;
    chk1("restart_ignored_valid", out_valid, 1'b1);
    chk1("restart_no_len_err", len_err, 1'b0);
    finish_fast(2);

    // Backpressure: result held while out_ready is low, extra beats refused
    out_ready = 1'b0;
    drive_reduce(vecs[1]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = $urandom;
      step();
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, vecs[1].exp);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    chk("bp_beats", 32'(beat_cnt), 32'd2);
    out_ready = 1'b1;
    step();
    chk1("bp_released", out_valid, 1'b0);
    chk1("bp_idle", busy, 1'b0);

    // Reset mid-stream after 2 of 4 beats
    start = 1'b1; op = OP_OR; len = CW'(4);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_0000;
    step();
    in_data = 32'h0000_FF00;
    step();
    in_data = 32'h0000_0003;
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_len_err", len_err, 1'b0);
    chk("midrst_out_data", out_data, 32'h0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk1("postrst_idle", busy, 1'b0);
    v_tmp = vecs[0];
    v_tmp.op = OP_OR; v_tmp.len = 2; v_tmp.exp = 32'h0000_0101;
    v_tmp.data[0] = 32'h0000_0100; v_tmp.data[1] = 32'h0000_0001;
    drive_reduce(v_tmp);
    finish_fast(2);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
